// File: rtl/ex_stage.sv
// Execute stage: latches one decoded instruction per handshake, evaluates ALU ops, and
// stalls on an iterative radix-2 divider when EX_DIVIDER_EN is defined.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_to_EX_valid,
    output logic         EX_allow_in,
    input  logic [107:0] to_EX_data,
    input  logic         MEM_allow_in,
    output logic         EX_to_MEM_valid,
    output logic [71:0]  to_MEM_data
);

    logic         ex_valid_q;
    logic [107:0] payload_q;
    logic         ready_go;

    logic [3:0]   alu_op;
    logic [31:0]  src1;
    logic [31:0]  src2;
    logic [31:0]  rkd_value;
    logic         mem_we;
    logic         res_from_mem;
    logic [4:0]   dest;
    logic         gr_we;
    logic [31:0]  alu_result;

    assign {alu_op, src1, src2, rkd_value, mem_we, res_from_mem, dest, gr_we} = payload_q;

    assign EX_allow_in     = ~ex_valid_q | (ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = ex_valid_q & ready_go;
    assign to_MEM_data     = {alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
        end else if (EX_allow_in) begin
            ex_valid_q <= ID_to_EX_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_q <= '0;
        end else if (EX_allow_in & ID_to_EX_valid) begin
            payload_q <= to_EX_data;
        end
    end

`ifdef EX_DIVIDER_EN
    typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic        q_neg_q;
    logic        r_neg_q;

    logic        is_div;
    logic        div_start;
    logic        div_fix;
    logic [31:0] dvnd_abs;
    logic [31:0] dvsr_abs;
    logic [32:0] trial;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] div_result;

    assign is_div    = (alu_op >= 4'd12);
    assign div_start = (state_q == DivIdle) & ex_valid_q & is_div;

    // Zero divisor skips sign handling so the remainder comes out as raw src1.
    assign div_fix  = ~alu_op[0] & (src2 != 32'd0);
    assign dvnd_abs = (div_fix & src1[31]) ? -src1 : src1;
    assign dvsr_abs = (div_fix & src2[31]) ? -src2 : src2;

    // Restoring step: shift the next dividend bit into the partial remainder, try subtract.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    always_comb begin
        rem_step = {rem_q[30:0], quo_q[31]};
        quo_step = {quo_q[30:0], 1'b0};
        if (!trial[32]) begin
            rem_step = trial[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end
    end

    assign quotient   = q_neg_q ? -quo_q : quo_q;
    assign remainder  = r_neg_q ? -rem_q : rem_q;
    assign div_result = alu_op[1] ? remainder : quotient;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DivIdle: if (ex_valid_q & is_div) state_d = DivBusy;
            DivBusy: if (cnt_q == 6'd31) state_d = DivDone;
            DivDone: if (EX_to_MEM_valid & MEM_allow_in) state_d = DivIdle;
            default: state_d = DivIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DivIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (div_start) begin
                cnt_q   <= '0;
                rem_q   <= '0;
                quo_q   <= dvnd_abs;
                dvsr_q  <= dvsr_abs;
                q_neg_q <= div_fix & (src1[31] ^ src2[31]);
                r_neg_q <= div_fix & src1[31];
            end else if (state_q == DivBusy) begin
                cnt_q <= cnt_q + 6'd1;
                rem_q <= rem_step;
                quo_q <= quo_step;
            end
        end
    end

    assign ready_go = ~ex_valid_q | ~is_div | (state_q == DivDone);
`else
    assign ready_go = 1'b1;
`endif

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            4'd0:    alu_result = src1 + src2;
            4'd1:    alu_result = src1 - src2;
            4'd2:    alu_result = {31'd0, $signed(src1) < $signed(src2)};
            4'd3:    alu_result = {31'd0, src1 < src2};
            4'd4:    alu_result = src1 & src2;
            4'd5:    alu_result = src1 | src2;
            4'd6:    alu_result = ~(src1 | src2);
            4'd7:    alu_result = src1 ^ src2;
            4'd8:    alu_result = src1 << src2[4:0];
            4'd9:    alu_result = src1 >> src2[4:0];
            4'd10:   alu_result = $signed(src1) >>> src2[4:0];
            4'd11:   alu_result = src2;
`ifdef EX_DIVIDER_EN
            default: alu_result = div_result;
`else
            default: alu_result = '0;
`endif
        endcase
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; expected MEM bundles are queued on acceptance and
// compared on each MEM handoff. Divide expectations follow EX_DIVIDER_EN.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ID_to_EX_valid;
    logic         EX_allow_in;
    logic [107:0] to_EX_data;
    logic         MEM_allow_in;
    logic         EX_to_MEM_valid;
    logic [71:0]  to_MEM_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [71:0] exp_q[$];

`ifdef EX_DIVIDER_EN
    localparam int DivLat = 34;
`else
    localparam int DivLat = 1;
`endif

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EX_valid  (ID_to_EX_valid),
        .EX_allow_in     (EX_allow_in),
        .to_EX_data      (to_EX_data),
        .MEM_allow_in    (MEM_allow_in),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .to_MEM_data     (to_MEM_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
`ifdef EX_DIVIDER_EN
        logic signed [31:0] sa, sb;
        logic [31:0] q, m;
        sa = a;
        sb = b;
`endif
        r = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~(a | b);
            4'd7:  r = a ^ b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd11: r = b;
            default: begin
`ifdef EX_DIVIDER_EN
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    m = a;
                end else if (!op[0]) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        q = 32'h8000_0000;
                        m = 32'd0;
                    end else begin
                        q = sa / sb;
                        m = sa % sb;
                    end
                end else begin
                    q = a / b;
                    m = a % b;
                end
                r = op[1] ? m : q;
`else
                r = 32'd0;
`endif
            end
        endcase
        return r;
    endfunction

    // Drives one instruction, queues its expected bundle when it is accepted.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rkd, input logic [7:0] tail);
        int n = 0;
        to_EX_data     = {op, a, b, rkd, tail};
        ID_to_EX_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (EX_allow_in) begin
                exp_q.push_back({model(op, a, b), rkd, tail});
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 72'(n), 72'(0));
                break;
            end
        end
        ID_to_EX_valid = 1'b0;
    endtask

    // Counts residency cycles until EX_to_MEM_valid rises.
    task automatic measure(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!EX_to_MEM_valid && n < 100);
        check(tag, 72'(n), 72'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 72'(exp_q.size()), 72'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && EX_to_MEM_valid && MEM_allow_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got %h expected none", to_MEM_data);
            end else begin
                check("out", to_MEM_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] stall_exp;
        int n;
        reset          = 1'b1;
        ID_to_EX_valid = 1'b0;
        to_EX_data     = '0;
        MEM_allow_in   = 1'b1;
        #1;
        check("rst_valid", 72'(EX_to_MEM_valid), 72'(0));
        check("rst_allow", 72'(EX_allow_in), 72'(1));
        check("rst_data", to_MEM_data, 72'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-cycle ops
        send(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h1234_5678, 8'hA5);
        measure("add_lat", 1);
        send(4'd10, 32'h8000_0000, 32'h24, 32'hDEAD_BEEF, 8'h3C);
        send(4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 8'h01);
        send(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 8'h80);
        send(4'd1, 32'd0, 32'd1, 32'h5555_AAAA, 8'h7E);
        send(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h1, 8'h42);
        send(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h2, 8'h43);
        send(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h3, 8'h44);
        send(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h4, 8'h45);
        send(4'd8, 32'h0000_00F1, 32'hFFFF_FFE4, 32'h5, 8'h46);
        send(4'd9, 32'h8000_00F1, 32'd31, 32'h6, 8'h47);
        send(4'd11, 32'h1111_1111, 32'hABCD_E000, 32'h7, 8'h48);
        drain();

        // Divides: latency, back-to-back, signs, zero divisor, overflow
        send(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hCAFE_0001, 8'h11);
        measure("div_lat", DivLat);
        send(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hCAFE_0002, 8'h12);
        send(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hCAFE_0003, 8'h13);
        measure("mod_b2b_lat", DivLat);
        send(4'd13, 32'd5, 32'd0, 32'h0, 8'h21);
        send(4'd15, 32'd5, 32'd0, 32'h0, 8'h22);
        send(4'd12, 32'hFFFF_FFF9, 32'd0, 32'h0, 8'h23);
        send(4'd14, 32'hFFFF_FFF9, 32'd0, 32'h0, 8'h24);
        send(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 8'h25);
        send(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 8'h26);
        send(4'd12, 32'd7, 32'hFFFF_FFFE, 32'h0, 8'h27);
        send(4'd14, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0, 8'h28);
        send(4'd13, 32'hFFFF_FFF0, 32'd3, 32'h0, 8'h29);
        send(4'd15, 32'hFFFF_FFF0, 32'd3, 32'h0, 8'h2A);
        drain();

        // MEM back-pressure on a finished divide, next instruction waiting on ID
        MEM_allow_in = 1'b0;
        send(4'd12, 32'hFFFF_FF9C, 32'd7, 32'hBEEF_0001, 8'h31);
        stall_exp      = {model(4'd12, 32'hFFFF_FF9C, 32'd7), 32'hBEEF_0001, 8'h31};
        to_EX_data     = {4'd0, 32'd40, 32'd2, 32'hBEEF_0002, 8'h32};
        ID_to_EX_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!EX_to_MEM_valid && n < 100);
        check("stall_ready_lat", 72'(n), 72'(DivLat));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_allow", 72'(EX_allow_in), 72'(0));
            check("stall_data", to_MEM_data, stall_exp);
        end
        @(posedge clk);
        #1;
        MEM_allow_in = 1'b1;
        @(negedge clk);
        check("handoff_allow", 72'(EX_allow_in), 72'(1));
        exp_q.push_back({model(4'd0, 32'd40, 32'd2), 32'hBEEF_0002, 8'h32});
        @(posedge clk);
        #1;
        ID_to_EX_valid = 1'b0;
        @(negedge clk);
        check("next_after_stall", 72'(EX_to_MEM_valid), 72'(1));
        drain();

        // Reset during divider BUSY
        send(4'd13, 32'd100, 32'd3, 32'h0, 8'h51);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_valid", 72'(EX_to_MEM_valid), 72'(0));
        check("midrst_allow", 72'(EX_allow_in), 72'(1));
        check("midrst_data", to_MEM_data, 72'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(4'd0, 32'd3, 32'd4, 32'h9, 8'h61);
        measure("post_rst_add_lat", 1);
        send(4'd15, 32'd100, 32'd7, 32'hA, 8'h62);
        measure("post_rst_div_lat", DivLat);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
